// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states, decode helpers.
package lsu_pkg;

   localparam logic [2:0] FunctB  = 3'b000;
   localparam logic [2:0] FunctH  = 3'b001;
   localparam logic [2:0] FunctW  = 3'b010;
   localparam logic [2:0] FunctBu = 3'b100;
   localparam logic [2:0] FunctHu = 3'b101;

   typedef enum logic [2:0] {
      StIdle,
      StLdRd,
      StLdCap,
      StStRd,
      StStMrg,
      StStWr
   } lsu_state_e;

   function automatic logic funct_legal(input logic [2:0] funct);
      return funct inside {FunctB, FunctH, FunctW, FunctBu, FunctHu};
   endfunction

   function automatic logic funct_is_half(input logic [2:0] funct);
      return funct == FunctH || funct == FunctHu;
   endfunction

   function automatic logic funct_is_word(input logic [2:0] funct);
      return funct == FunctW;
   endfunction

endpackage

// File: rtl/lsu_lane_fmt.sv
// Lane extract/extend for loads and lane merge for sub-word stores (purely combinational).
module lsu_lane_fmt
   import lsu_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [31:0] wdata,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct,
   output logic [31:0] load_data,
   output logic [31:0] merge_data
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      byte_lane = rdata[{offset, 3'b000} +: 8];
      half_lane = offset[1] ? rdata[31:16] : rdata[15:0];

      unique case (funct)
         FunctB:  load_data = {{24{byte_lane[7]}}, byte_lane};
         FunctBu: load_data = {24'h000000, byte_lane};
         FunctH:  load_data = {{16{half_lane[15]}}, half_lane};
         FunctHu: load_data = {16'h0000, half_lane};
         default: load_data = rdata;
      endcase

      merge_data = wdata;
      if (funct[1:0] == 2'b00) begin
         merge_data = rdata;
         merge_data[{offset, 3'b000} +: 8] = wdata[7:0];
      end else if (funct[1:0] == 2'b01) begin
         merge_data = rdata;
         merge_data[{offset[1], 4'b0000} +: 16] = wdata[15:0];
      end
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer for a single-port synchronous RAM; sub-word stores use read-modify-write.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of force-aligning them.
module lsu_ctrl
   import lsu_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
`ifdef LSU_MISALIGN_TRAP_EN
   output logic        misalign,
`endif
   output logic        mem_en,
   output logic        mem_we,
   output logic [9:0]  mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   lsu_state_e  state_q, state_d;
   logic [2:0]  funct_q, funct_d;
   logic [11:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        we_q, we_d;
   logic        resp_valid_q, resp_valid_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic        accept, noop;
   logic [11:0] addr_in;
   logic [31:0] load_data, merge_data;
   logic        unused_addr;

   // Only the 4 KiB window addressed by the RAM matters.
   assign unused_addr = ^req_addr[31:12];

`ifdef LSU_MISALIGN_TRAP_EN
   logic misaligned;
   logic misalign_q, misalign_d;

   always_comb begin
      addr_in    = req_addr[11:0];
      misaligned = (funct_is_half(req_funct) && req_addr[0]) ||
                   (funct_is_word(req_funct) && req_addr[1:0] != 2'b00);
      noop       = !funct_legal(req_funct) || misaligned;
      misalign_d = accept && misaligned;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) misalign_q <= 1'b0;
      else        misalign_q <= misalign_d;
   end

   assign misalign = misalign_q;
`else
   always_comb begin
      addr_in = req_addr[11:0];
      if (funct_is_half(req_funct))      addr_in[0]   = 1'b0;
      else if (funct_is_word(req_funct)) addr_in[1:0] = 2'b00;
      noop = !funct_legal(req_funct);
   end
`endif

   assign accept = req_valid && (state_q == StIdle);

   lsu_lane_fmt u_lane_fmt (
      .rdata      (mem_rdata),
      .wdata      (wdata_q),
      .offset     (addr_q[1:0]),
      .funct      (funct_q),
      .load_data  (load_data),
      .merge_data (merge_data)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= StIdle;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (accept && !noop) begin
               if (!req_we)                        state_d = StLdRd;
               else if (funct_is_word(req_funct))  state_d = StStWr;
               else                                state_d = StStRd;
            end
         end
         StLdRd:  state_d = StLdCap;
         StLdCap: state_d = StIdle;
         StStRd:  state_d = StStMrg;
         StStMrg: state_d = StStWr;
         StStWr:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      req_ready  = (state_q == StIdle);
      mem_en     = (state_q == StLdRd) || (state_q == StStRd);
      mem_we     = (state_q == StStWr);
      mem_addr   = addr_q[11:2];
      mem_wdata  = wdata_q;
      resp_valid = resp_valid_q;
      resp_rdata = resp_rdata_q;
   end

   always_comb begin
      funct_d      = funct_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      we_d         = we_q;
      resp_valid_d = 1'b0;
      resp_rdata_d = resp_rdata_q;
      if (accept) begin
         funct_d = req_funct;
         addr_d  = addr_in;
         wdata_d = req_wdata;
         we_d    = req_we;
         if (noop) begin
            resp_valid_d = 1'b1;
            resp_rdata_d = 32'h0;
         end
      end
      unique case (state_q)
         StLdCap: begin
            resp_valid_d = 1'b1;
            resp_rdata_d = load_data;
         end
         StStMrg: wdata_d = merge_data;
         StStWr: begin
            resp_valid_d = 1'b1;
            resp_rdata_d = 32'h0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         funct_q      <= 3'b000;
         addr_q       <= 12'h000;
         wdata_q      <= 32'h0;
         we_q         <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 32'h0;
      end else begin
         funct_q      <= funct_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         we_q         <= we_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
      end
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a one-cycle-latency RAM model.
module tb_lsu_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_funct;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        mem_en, mem_we;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata, mem_rdata;
`ifdef LSU_MISALIGN_TRAP_EN
   logic        misalign;
`endif

   logic [31:0] ram [1024];
   logic        poke_en = 1'b0;
   logic [9:0]  poke_addr = 10'h0;
   logic [31:0] poke_data = 32'h0;

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   lsu_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct  (req_funct),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
`ifdef LSU_MISALIGN_TRAP_EN
      .misalign   (misalign),
`endif
      .mem_en     (mem_en),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   always @(posedge clk) begin
      if (poke_en)     ram[poke_addr] <= poke_data;
      else if (mem_we) ram[mem_addr] <= mem_wdata;
      if (mem_en) mem_rdata <= ram[mem_addr];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
   endtask

   task automatic poke(input logic [9:0] a, input logic [31:0] d);
      poke_en   = 1'b1;
      poke_addr = a;
      poke_data = d;
      @(negedge clk);
      poke_en   = 1'b0;
   endtask

   // Issue at the current negedge (C0) and follow the op until resp_valid, counting RAM strobes.
   task automatic do_op(input string tag, input logic we, input logic [2:0] f,
                        input logic [31:0] addr, input logic [31:0] wd, input int exp_lat,
                        input logic [31:0] exp_rdata, input int exp_en, input int exp_we);
      int lat, n_en, n_we, n_ovl;
      lat = 99; n_en = 0; n_we = 0; n_ovl = 0;
      check({tag, " ready"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_we    = we;
      req_funct = f;
      req_addr  = addr;
      req_wdata = wd;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (k == 1) req_valid = 1'b0;
         n_en += int'(mem_en);
         n_we += int'(mem_we);
         if (mem_en && mem_we) n_ovl++;
         if (resp_valid) begin
            lat = k;
            break;
         end
      end
      check({tag, " latency"}, 32'(lat), 32'(exp_lat));
      check({tag, " rdata"}, resp_rdata, exp_rdata);
      check({tag, " mem_en count"}, 32'(n_en), 32'(exp_en));
      check({tag, " mem_we count"}, 32'(n_we), 32'(exp_we));
      check({tag, " en/we overlap"}, 32'(n_ovl), 32'd0);
   endtask

   initial begin
      int n_we_rst;
      reset     = 1'b0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_funct = 3'b000;
      req_addr  = 32'h0;
      req_wdata = 32'h0;
      repeat (2) @(negedge clk);
      check("rst resp_valid", 32'(resp_valid), 32'd0);
      check("rst resp_rdata", resp_rdata, 32'h0);
      check("rst mem_en", 32'(mem_en), 32'd0);
      check("rst mem_we", 32'(mem_we), 32'd0);
      check("rst mem_addr", 32'(mem_addr), 32'h0);
      check("rst mem_wdata", mem_wdata, 32'h0);
      reset = 1'b1;
      @(negedge clk);
      check("post-rst ready", 32'(req_ready), 32'd1);

      poke(10'd0, 32'h8899AABB);
      poke(10'd1, 32'h55667788);
      do_op("LB 0x2",  1'b0, 3'b000, 32'h2, 32'h0, 3, 32'hFFFFFF99, 1, 0);
      do_op("LBU 0x2", 1'b0, 3'b100, 32'h2, 32'h0, 3, 32'h00000099, 1, 0);
      do_op("LH 0x2",  1'b0, 3'b001, 32'h2, 32'h0, 3, 32'hFFFF8899, 1, 0);
      do_op("LHU 0x0", 1'b0, 3'b101, 32'h0, 32'h0, 3, 32'h0000AABB, 1, 0);
      do_op("LB 0x0",  1'b0, 3'b000, 32'h0, 32'h0, 3, 32'hFFFFFFBB, 1, 0);
      do_op("LBU 0x3", 1'b0, 3'b100, 32'h3, 32'h0, 3, 32'h00000088, 1, 0);
      @(negedge clk);
      check("rdata hold valid", 32'(resp_valid), 32'd0);
      check("rdata hold", resp_rdata, 32'h00000088);

      poke(10'd0, 32'h11223344);
      do_op("SH 0x2", 1'b1, 3'b001, 32'h2, 32'h0000BEEF, 4, 32'h0, 1, 1);
      check("SH ram", ram[0], 32'hBEEF3344);
      do_op("SB 0x1", 1'b1, 3'b000, 32'h1, 32'h123456AA, 4, 32'h0, 1, 1);
      check("SB ram", ram[0], 32'hBEEFAA44);

      do_op("SW 0x10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 2, 32'h0, 0, 1);
      do_op("LW 0x10 b2b", 1'b0, 3'b010, 32'h10, 32'h0, 3, 32'hDEADBEEF, 1, 0);

`ifdef LSU_MISALIGN_TRAP_EN
      do_op("LW 0x6 trap", 1'b0, 3'b010, 32'h6, 32'h0, 1, 32'h0, 0, 0);
      check("LW 0x6 misalign", 32'(misalign), 32'd1);
`else
      do_op("LW 0x6 align", 1'b0, 3'b010, 32'h6, 32'h0, 3, 32'h55667788, 1, 0);
`endif

      // Reset in the ST_MRG cycle of an SB must abandon the write.
      @(negedge clk);
      poke(10'd2, 32'hCAFEF00D);
      check("SB rst ready", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_funct = 3'b000;
      req_addr  = 32'h8;
      req_wdata = 32'h00000011;
      @(negedge clk);
      req_valid = 1'b0;
      check("SB rst C1 mem_en", 32'(mem_en), 32'd1);
      @(negedge clk);
      reset = 1'b0;
      n_we_rst = 0;
      repeat (3) begin
         @(negedge clk);
         n_we_rst += int'(mem_we);
      end
      check("in-rst resp_rdata", resp_rdata, 32'h0);
      check("in-rst resp_valid", 32'(resp_valid), 32'd0);
      reset = 1'b1;
      @(negedge clk);
      check("SB rst ready after release", 32'(req_ready), 32'd1);
      repeat (4) begin
         n_we_rst += int'(mem_we);
         @(negedge clk);
      end
      check("SB rst no write", 32'(n_we_rst), 32'd0);
      check("SB rst ram", ram[2], 32'hCAFEF00D);

      do_op("noop 011", 1'b0, 3'b011, 32'h4, 32'h0, 1, 32'h0, 0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
      check("noop misalign", 32'(misalign), 32'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port req_valid, input, 1 bit: pipeline presents a memory op.
REQ-004 SHALL have port req_ready, output, 1 bit: op accepted when req_valid && req_ready.
REQ-005 SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-006 SHALL have port req_funct, input, 3 bits: RV funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-007 SHALL have ports req_addr and req_wdata, inputs, 32 bits each: byte address and store data.
REQ-008 SHALL have port resp_valid, output, 1 bit: one-cycle completion pulse.
REQ-009 SHALL have port resp_rdata, output, 32 bits: formatted load result, 0 for stores.
REQ-010 SHALL have ports mem_en and mem_we, outputs, 1 bit each: RAM read enable and write enable.
REQ-011 SHALL have port mem_addr, output, 10 bits: word address = addr[11:2].
REQ-012 SHALL have port mem_wdata, output, 32 bits: full word written to RAM.
REQ-013 SHALL have port mem_rdata, input, 32 bits: RAM data, valid one cycle after mem_en.

Function
REQ-014 SHALL implement states IDLE, LD_RD, LD_CAP, ST_RD, ST_MRG and ST_WR.
REQ-015 SHALL drive req_ready=1 only in IDLE and latch funct, addr, wdata and we on acceptance.
REQ-016 SHALL sequence a load accepted in C0 as LD_RD in C1 (mem_en=1), then LD_CAP in C2, then resp_valid=1 in C3.
REQ-017 SHALL select the load lane by addr[1:0] (byte) or addr[1] (half), then sign-extend for B/H and zero-extend for BU/HU.
REQ-018 SHALL sequence SW accepted in C0 as ST_WR in C1 (mem_we=1, mem_wdata=wdata), then resp_valid in C2.
REQ-019 SHALL sequence SB/SH as read-modify-write: ST_RD in C1 (mem_en), ST_MRG in C2 (replace the addressed lane of mem_rdata), ST_WR in C3, then resp_valid in C4.
REQ-020 SHALL never assert mem_en and mem_we in the same cycle.
REQ-021 SHALL treat funct 011, 110, 111 as a no-op: no RAM access, resp_valid in C1, resp_rdata=0.
REQ-022 SHALL allow IDLE to accept a new op in the same cycle that resp_valid is high.
REQ-023 SHALL hold resp_rdata stable until the next resp_valid.

Reset
REQ-024 SHALL force state to IDLE and clear resp_valid, resp_rdata, mem_en, mem_we, mem_addr, mem_wdata and the latched request when reset=0, independent of clk.
REQ-025 SHALL drop any in-flight op on reset with no RAM write issued afterwards, then raise req_ready=1 in the first cycle after reset deasserts.

Configuration
REQ-026 SHALL, with LSU_MISALIGN_TRAP_EN defined, add output misalign (1 bit, reset 0) and, for H/HU/SH with addr[0]=1 or W/SW with addr[1:0]!=0, skip RAM access and assert resp_valid and misalign together in C1 with resp_rdata=0.
REQ-027 SHALL, without LSU_MISALIGN_TRAP_EN, omit the misalign port and force-align addresses (clear addr[0] for half ops, addr[1:0] for word ops) before normal processing.

Structure
REQ-028 SHALL take funct3 encodings and the state encoding from shared package lsu_pkg.
REQ-029 SHALL place lane extract/extend and lane merge logic in one combinational sub-module, lsu_lane_fmt.

Verification
REQ-030 SHALL cover: RAM word 0x0 = 0x8899AABB, LB addr 0x2 -> resp_rdata 0xFFFFFF99 in C3; LBU addr 0x2 -> 0x00000099.
REQ-031 SHALL cover: word = 0x11223344, SH addr 0x2 with wdata 0x0000BEEF -> word becomes 0xBEEF3344, resp_valid in C4, no mem_en/mem_we overlap.
REQ-032 SHALL cover: SW addr 0x10 with wdata 0xDEADBEEF, then back-to-back LW addr 0x10 accepted on the ack cycle -> resp_rdata 0xDEADBEEF.
REQ-033 SHALL cover: LW addr 0x6 -> with the macro, misalign=1, resp_rdata=0, no RAM access in C1; without it, the word at 0x4 is returned.
REQ-034 SHALL cover: reset=0 asserted in the ST_MRG cycle of an SB -> no mem_we pulse, RAM unchanged, req_ready=1 after release.
REQ-035 SHALL cover: funct 011 load -> resp_valid in C1, resp_rdata=0, mem_en never asserted.
